// File: rtl/seq_pkg.sv
// Shared definitions for the seq_ctrl instruction sequencer: opcodes, ALU
// select encodings, FSM states, decode bundle and instruction field helpers.
package seq_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_1    = 6'd1;
    localparam logic [5:0] OP_2    = 6'd2;
    localparam logic [5:0] OP_3    = 6'd3;
    localparam logic [5:0] OP_4    = 6'd4;
    localparam logic [5:0] OP_5    = 6'd5;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_1   = 3'd1;
    localparam logic [2:0] ALU_2   = 3'd2;
    localparam logic [2:0] ALU_3   = 3'd3;
    localparam logic [2:0] ALU_4   = 3'd4;
    localparam logic [2:0] ALU_5   = 3'd5;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RA_LSB  = 16;
    localparam int RB_LSB  = 11;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALTED,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       is_branch;
        logic       writes_rf;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[OP_LSB +: 6];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_ra(input logic [31:0] ir);
        return ir[RA_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rb(input logic [31:0] ir);
        return ir[RB_LSB +: 5];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ir);
        return ir[IMM_LSB +: 16];
    endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Instruction-memory req/ack fetch channel between the sequencer (master)
// and the instruction memory (slave).
interface seq_ctrl_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/seq_decode.sv
// Combinational opcode decode. Unknown opcodes write the register file as
// op 0 unless SEQ_ILLEGAL_TRAP_EN is defined, in which case they only trap.
module seq_decode
    import seq_pkg::*;
(
    input  logic [5:0] op,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (op)
            OP_ADD, OP_1, OP_2, OP_3, OP_4, OP_5: begin
                dec.alu_ctrl  = op[2:0];
                dec.writes_rf = 1'b1;
            end
            OP_BEQ:  dec.is_branch = 1'b1;
            OP_HALT: dec.is_halt   = 1'b1;
            default: begin
                dec.is_illegal = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
`ifdef SEQ_ILLEGAL_TRAP_EN
                dec.writes_rf  = 1'b0;
`else
                dec.writes_rf  = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the ALU/branch
// datapath. Optional feature macro: SEQ_ILLEGAL_TRAP_EN (adds illegal_op).
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    seq_ctrl_if.master      imem,
    output logic [2:0]      alu_ctrl,
    input  logic            alu_zero,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [31:0]       ir_reg, ir_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [31:0]       imm_sx;
    logic [PC_W-1:0]   br_target;
    dec_t              dec;

    seq_decode u_decode (
        .op  (f_op(ir_reg)),
        .dec (dec)
    );

    // Branch offset is relative to the following instruction and wraps in PC_W bits.
    assign imm_sx    = {{16{ir_reg[15]}}, f_imm(ir_reg)};
    assign br_target = pc_reg + PC_W'(1) + imm_sx[PC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        ir_next        = ir_reg;
        tmo_next       = tmo_reg;
        imem.imem_req  = 1'b0;
        imem.imem_addr = '0;
        alu_ctrl       = ALU_ADD;
        rf_raddr_a     = '0;
        rf_raddr_b     = '0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        case (state_reg)
            ST_IDLE, ST_HALTED, ST_FAULT: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    tmo_next   = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = pc_reg;
                // An ack in the final allowed cycle takes priority over the timeout.
                if (imem.imem_ack) begin
                    ir_next    = imem.imem_rdata;
                    tmo_next   = '0;
                    state_next = ST_DECODE;
                end else if (tmo_reg == TMO_LAST) begin
                    tmo_next   = '0;
                    state_next = ST_FAULT;
                end else begin
                    tmo_next   = tmo_reg + TMO_W'(1);
                end
            end
            ST_DECODE: begin
                rf_raddr_a = f_ra(ir_reg);
                rf_raddr_b = f_rb(ir_reg);
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                rf_raddr_a = f_ra(ir_reg);
                rf_raddr_b = f_rb(ir_reg);
                alu_ctrl   = dec.alu_ctrl;
                if (dec.is_halt) begin
                    state_next = ST_HALTED;
                end else if (dec.is_branch) begin
                    pc_next    = alu_zero ? br_target : pc_reg + PC_W'(1);
                    state_next = ST_FETCH;
                end else if (dec.is_illegal && !dec.writes_rf) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                rf_raddr_a = f_ra(ir_reg);
                rf_raddr_b = f_rb(ir_reg);
                rf_we      = 1'b1;
                rf_waddr   = f_rd(ir_reg);
                pc_next    = pc_reg + PC_W'(1);
                state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_reg;

    // Remembers why FAULT was entered; a fetch timeout clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_EXEC && state_next == ST_FAULT) begin
            illegal_reg <= 1'b1;
        end else if (state_next == ST_FETCH || state_next == ST_FAULT) begin
            illegal_reg <= 1'b0;
        end
    end

    assign illegal_op = (state_reg == ST_FAULT) && illegal_reg;
`endif

    assign pc     = pc_reg;
    assign busy   = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                    (state_reg == ST_EXEC)  || (state_reg == ST_WB);
    assign halted = (state_reg == ST_HALTED);
    assign fault  = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: expected fetch addresses and register
// writes are queued as instructions are served and popped when the DUT acts.
module tb_seq_ctrl;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        alu_zero = 1'b0;
    logic [2:0]  alu_ctrl;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we;
    logic [15:0] pc;
    logic        busy, halted, fault;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    seq_ctrl_if #(.PC_W(16)) imem ();

    seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem       (imem),
        .alu_ctrl   (alu_ctrl),
        .alu_zero   (alu_zero),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault)
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int addr_q[$];
    int wr_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] mk_br(input logic [15:0] imm);
        return {OP_BEQ, 10'd0, imm};
    endfunction

    task automatic pop_addr(output int v);
        if (addr_q.size() == 0) v = -1;
        else v = addr_q.pop_front();
    endtask

    task automatic pop_wr(output int v);
        if (wr_q.size() == 0) v = -1;
        else v = wr_q.pop_front();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Acks the pending fetch this cycle; returns in the DECODE cycle.
    task automatic ack_now(input logic [31:0] instr);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = instr;
        tick();
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
    endtask

    // Runs one ALU instruction to completion; returns in the next FETCH cycle.
    task automatic run_alu_quiet();
        ack_now(mk(OP_ADD, 5'd0, 5'd0, 5'd0));
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({imem.imem_req, imem.imem_addr, busy, halted, fault, rf_we, alu_ctrl, pc,
             rf_raddr_a, rf_raddr_b, rf_waddr} !== '0)
            $display("FAIL reset_outputs: got req=%0b addr=%0h busy=%0b halted=%0b fault=%0b we=%0b alu=%0d pc=%0h, want all 0",
                     imem.imem_req, imem.imem_addr, busy, halted, fault, rf_we, alu_ctrl, pc);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({busy, imem.imem_req, pc} !== '0)
            $display("FAIL idle_hold: got busy=%0b req=%0b pc=%0h, want 0 0 0", busy, imem.imem_req, pc);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        int e;
        addr_q.push_back(0);
        start_pulse();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e || busy !== 1'b1)
            $display("FAIL alu_first_fetch: got req=%0b addr=%0h busy=%0b, want 1 %0h 1", imem.imem_req, imem.imem_addr, busy, e);
        else pass_cnt++;
        wr_q.push_back(3);
        addr_q.push_back(1);
        ack_now(mk(OP_1, 5'd3, 5'd1, 5'd2));
        total_cnt++;
        if ({rf_raddr_a, rf_raddr_b} !== {5'd1, 5'd2} || imem.imem_req !== 1'b0)
            $display("FAIL alu_decode: got ra=%0d rb=%0d req=%0b, want 1 2 0", rf_raddr_a, rf_raddr_b, imem.imem_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (alu_ctrl !== 3'd1 || rf_we !== 1'b0)
            $display("FAIL alu_exec: got alu_ctrl=%0d we=%0b, want 1 0", alu_ctrl, rf_we);
        else pass_cnt++;
        tick();
        pop_wr(e);
        total_cnt++;
        if (rf_we !== 1'b1 || int'(rf_waddr) !== e || alu_ctrl !== 3'd0 || rf_raddr_a !== 5'd1)
            $display("FAIL alu_wb: got we=%0b waddr=%0d alu=%0d ra=%0d, want 1 %0d 0 1", rf_we, rf_waddr, alu_ctrl, rf_raddr_a, e);
        else pass_cnt++;
        tick();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e || rf_we !== 1'b0)
            $display("FAIL alu_next_fetch: got req=%0b addr=%0h we=%0b, want 1 %0h 0", imem.imem_req, imem.imem_addr, rf_we, e);
        else pass_cnt++;
    endtask

    task automatic test_delayed_ack();
        int e;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'd1 || rf_raddr_a !== 5'd0)
                $display("FAIL dly_stable[%0d]: got req=%0b addr=%0h ra=%0d, want 1 1 0", i, imem.imem_req, imem.imem_addr, rf_raddr_a);
            else pass_cnt++;
            tick();
        end
        wr_q.push_back(7);
        addr_q.push_back(2);
        ack_now(mk(OP_2, 5'd7, 5'd4, 5'd5));
        tick();
        total_cnt++;
        if (alu_ctrl !== 3'd2)
            $display("FAIL dly_exec: got alu_ctrl=%0d, want 2", alu_ctrl);
        else pass_cnt++;
        tick();
        pop_wr(e);
        total_cnt++;
        if (rf_we !== 1'b1 || int'(rf_waddr) !== e)
            $display("FAIL dly_wb: got we=%0b waddr=%0d, want 1 %0d", rf_we, rf_waddr, e);
        else pass_cnt++;
        tick();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL dly_next_fetch: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        int e;
        while (imem.imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total_cnt++;
        if (n !== 15)
            $display("FAIL timeout_cycles: got %0d request cycles, want 15", n);
        else pass_cnt++;
        total_cnt++;
        if ({fault, busy, imem.imem_req, halted} !== 4'b1000)
            $display("FAIL timeout_fault: got fault=%0b busy=%0b req=%0b halted=%0b, want 1 0 0 0", fault, busy, imem.imem_req, halted);
        else pass_cnt++;
`ifdef SEQ_ILLEGAL_TRAP_EN
        total_cnt++;
        if (illegal_op !== 1'b0)
            $display("FAIL timeout_not_illegal: got illegal_op=%0b, want 0", illegal_op);
        else pass_cnt++;
`endif
        repeat (3) tick();
        total_cnt++;
        if (fault !== 1'b1 || imem.imem_req !== 1'b0)
            $display("FAIL fault_hold: got fault=%0b req=%0b, want 1 0", fault, imem.imem_req);
        else pass_cnt++;
        addr_q.push_back(0);
        start_pulse();
        pop_addr(e);
        total_cnt++;
        if (fault !== 1'b0 || imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL fault_restart: got fault=%0b req=%0b addr=%0h, want 0 1 %0h", fault, imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
    endtask

    task automatic test_ack_boundary();
        int e;
        repeat (14) tick();
        total_cnt++;
        if (imem.imem_req !== 1'b1 || fault !== 1'b0)
            $display("FAIL bnd_last_cycle: got req=%0b fault=%0b, want 1 0", imem.imem_req, fault);
        else pass_cnt++;
        wr_q.push_back(1);
        addr_q.push_back(1);
        ack_now(mk(OP_ADD, 5'd1, 5'd0, 5'd0));
        total_cnt++;
        if ({fault, busy} !== 2'b01)
            $display("FAIL bnd_ack_wins: got fault=%0b busy=%0b, want 0 1", fault, busy);
        else pass_cnt++;
        tick();
        tick();
        pop_wr(e);
        total_cnt++;
        if (rf_we !== 1'b1 || int'(rf_waddr) !== e)
            $display("FAIL bnd_wb: got we=%0b waddr=%0d, want 1 %0d", rf_we, rf_waddr, e);
        else pass_cnt++;
        tick();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL bnd_next_fetch: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        int e;
        logic we_seen = 1'b0;
        repeat (3) run_alu_quiet();
        total_cnt++;
        if (pc !== 16'd4 || imem.imem_req !== 1'b1)
            $display("FAIL br_setup: got pc=%0h req=%0b, want 4 1", pc, imem.imem_req);
        else pass_cnt++;
        alu_zero = 1'b1;
        addr_q.push_back(3);
        ack_now(mk_br(16'hFFFE));
        we_seen |= rf_we;
        tick();
        we_seen |= rf_we;
        total_cnt++;
        if (alu_ctrl !== 3'd0)
            $display("FAIL beq_ctrl: got alu_ctrl=%0d, want 0", alu_ctrl);
        else pass_cnt++;
        tick();
        alu_zero = 1'b0;
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL beq_taken: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
        run_alu_quiet();
        addr_q.push_back(5);
        ack_now(mk_br(16'hFFFE));
        we_seen |= rf_we;
        tick();
        we_seen |= rf_we;
        tick();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL beq_not_taken: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
        total_cnt++;
        if (we_seen !== 1'b0)
            $display("FAIL beq_no_we: got rf_we seen=%0b, want 0", we_seen);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        int e;
        int reqs = 0;
        repeat (2) run_alu_quiet();
        ack_now(mk(OP_HALT, 5'd0, 5'd0, 5'd0));
        tick();
        tick();
        total_cnt++;
        if ({halted, busy, imem.imem_req} !== 3'b100 || pc !== 16'd7)
            $display("FAIL halt_state: got halted=%0b busy=%0b req=%0b pc=%0h, want 1 0 0 7", halted, busy, imem.imem_req, pc);
        else pass_cnt++;
        repeat (5) begin
            tick();
            reqs += int'(imem.imem_req);
        end
        total_cnt++;
        if (reqs !== 0 || halted !== 1'b1)
            $display("FAIL halt_quiet: got %0d req cycles halted=%0b, want 0 1", reqs, halted);
        else pass_cnt++;
        addr_q.push_back(0);
        start_pulse();
        pop_addr(e);
        total_cnt++;
        if (halted !== 1'b0 || imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL halt_restart: got halted=%0b req=%0b addr=%0h, want 0 1 %0h", halted, imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int e;
        alu_zero = 1'b1;
        addr_q.push_back(16'hFFFF);
        ack_now(mk_br(16'hFFFE));
        tick();
        tick();
        alu_zero = 1'b0;
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL wrap_branch: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
        wr_q.push_back(2);
        addr_q.push_back(0);
        ack_now(mk(OP_3, 5'd2, 5'd0, 5'd0));
        tick();
        tick();
        pop_wr(e);
        total_cnt++;
        if (rf_we !== 1'b1 || int'(rf_waddr) !== e)
            $display("FAIL wrap_wb: got we=%0b waddr=%0d, want 1 %0d", rf_we, rf_waddr, e);
        else pass_cnt++;
        tick();
        pop_addr(e);
        total_cnt++;
        if (imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL wrap_pc: got req=%0b addr=%0h, want 1 %0h", imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        run_alu_quiet();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (imem.imem_req !== 1'b0)
            $display("FAIL rst_async_req: got req=%0b, want 0", imem.imem_req);
        else pass_cnt++;
        total_cnt++;
        if ({busy, halted, fault, rf_we, alu_ctrl, pc, imem.imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr} !== '0)
            $display("FAIL rst_async_outputs: got busy=%0b pc=%0h addr=%0h, want 0 0 0", busy, pc, imem.imem_addr);
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({busy, imem.imem_req} !== 2'b00)
            $display("FAIL rst_idle: got busy=%0b req=%0b, want 0 0", busy, imem.imem_req);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int e;
        start_pulse();
        ack_now(mk(6'd20, 5'd9, 5'd0, 5'd0));
        tick();
        total_cnt++;
        if (alu_ctrl !== 3'd0)
            $display("FAIL ill_exec_ctrl: got alu_ctrl=%0d, want 0", alu_ctrl);
        else pass_cnt++;
        tick();
`ifdef SEQ_ILLEGAL_TRAP_EN
        total_cnt++;
        if ({fault, illegal_op, rf_we, busy} !== 4'b1100)
            $display("FAIL ill_trap: got fault=%0b illegal_op=%0b we=%0b busy=%0b, want 1 1 0 0", fault, illegal_op, rf_we, busy);
        else pass_cnt++;
`else
        wr_q.push_back(9);
        addr_q.push_back(1);
        pop_wr(e);
        total_cnt++;
        if (rf_we !== 1'b1 || int'(rf_waddr) !== e || fault !== 1'b0)
            $display("FAIL ill_as_op0: got we=%0b waddr=%0d fault=%0b, want 1 %0d 0", rf_we, rf_waddr, fault, e);
        else pass_cnt++;
        tick();
        pop_addr(e);
        total_cnt++;
        if (rf_we !== 1'b0 || imem.imem_req !== 1'b1 || int'(imem.imem_addr) !== e)
            $display("FAIL ill_next_fetch: got we=%0b req=%0b addr=%0h, want 0 1 %0h", rf_we, imem.imem_req, imem.imem_addr, e);
        else pass_cnt++;
`endif
    endtask

    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        test_reset();
        test_alu();
        test_delayed_ack();
        test_timeout();
        test_ack_boundary();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
